sound_event_queue: RTL and testbench



---
 rtl/sound_pkg.sv | 17 +
 rtl/sound_ev_fifo.sv | 56 +++++
 rtl/sound_event_queue.sv | 128 ++++++++++++
 tb/tb_sound_event_queue.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types and default timing constants for the sound event queue.
package sound_pkg;

  typedef enum logic [0:0] {
    SEV_EAT     = 1'b0,
    SEV_SUCCESS = 1'b1
  } sound_ev_t;

  localparam int SEV_DEPTH_DEF     = 4;
  localparam int SEV_HOLD_LONG_DEF = 12;
  localparam int SEV_HOLD_TICK_DEF = 4;

  function automatic int sev_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sound_ev_fifo.sv
// Synchronous FIFO of queued sound events with flush and head/tail peek.
module sound_ev_fifo
  import sound_pkg::*;
#(
  parameter int  DEPTH = SEV_DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  sound_ev_t     push_code,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output sound_ev_t     head,
  output sound_ev_t     tail
);

  sound_ev_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign tail    = mem[wr_ptr - PW'(1)];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

endmodule

// File: rtl/sound_event_queue.sv
// Turns raw game event levels into paced one-cycle sound pulses.
// Optional SOUND_EVQ_COALESCE_EN: drop a success/eat equal to the queue tail.
module sound_event_queue
  import sound_pkg::*;
#(
  parameter int  DEPTH     = SEV_DEPTH_DEF,
  parameter int  HOLD_LONG = SEV_HOLD_LONG_DEF,
  parameter int  HOLD_TICK = SEV_HOLD_TICK_DEF,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          req_failure,
  input  logic          req_success,
  input  logic          req_eat,
  input  logic          req_tick,
  output logic          failure,
  output logic          success,
  output logic          eat,
  output logic          tick,
  output logic [CW-1:0] queue_count,
  output logic          overflow
);

  localparam int HOLD_MAX = sev_max(HOLD_LONG, HOLD_TICK);
  localparam int HW       = $clog2(HOLD_MAX + 1);

  logic          req_failure_p0;
  logic          req_success_p0;
  logic          req_eat_p0;
  logic          req_tick_p0;
  logic          vsync_p0;
  logic [HW-1:0] hold;

  logic          fail_e;
  logic          succ_e;
  logic          eat_e;
  logic          tick_e;
  logic          vs_e;
  logic          hold_zero;

  logic          fifo_full;
  logic          fifo_empty;
  sound_ev_t     fifo_head;
  sound_ev_t     fifo_tail;

  logic          pop;
  logic          push;
  logic          push_drop;
  logic          tick_ok;
  logic          coalesce;
  sound_ev_t     push_code;

  assign fail_e    = req_failure & ~req_failure_p0;
  assign succ_e    = req_success & ~req_success_p0;
  assign eat_e     = req_eat & ~req_eat_p0;
  assign tick_e    = req_tick & ~req_tick_p0;
  assign vs_e      = vsync & ~vsync_p0;
  assign hold_zero = (hold == '0);

`ifndef SOUND_EVQ_COALESCE_EN
  logic tail_unused;
  assign tail_unused = ^fifo_tail;
`endif

  // Arbitration: failure overrides everything, then pop, then tick.
  always_comb begin
    push_code = succ_e ? SEV_SUCCESS : SEV_EAT;
    pop       = vs_e & hold_zero & ~fifo_empty & ~fail_e;
`ifdef SOUND_EVQ_COALESCE_EN
    coalesce  = ~fifo_empty & (fifo_tail == push_code);
`else
    coalesce  = 1'b0;
`endif
    push      = ~fail_e & (succ_e | eat_e) & ~coalesce;
    push_drop = push & fifo_full & ~pop;
    tick_ok   = tick_e & hold_zero & fifo_empty & ~pop & ~fail_e & ~succ_e & ~eat_e;
  end

  sound_ev_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_code (push_code),
    .pop       (pop),
    .flush     (fail_e),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (queue_count),
    .head      (fifo_head),
    .tail      (fifo_tail)
  );

  // Registered outputs and hold counter; reset re-arms edge detectors on current levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_failure_p0 <= req_failure;
      req_success_p0 <= req_success;
      req_eat_p0     <= req_eat;
      req_tick_p0    <= req_tick;
      vsync_p0       <= vsync;
      failure        <= 1'b0;
      success        <= 1'b0;
      eat            <= 1'b0;
      tick           <= 1'b0;
      overflow       <= 1'b0;
      hold           <= '0;
    end else begin
      req_failure_p0 <= req_failure;
      req_success_p0 <= req_success;
      req_eat_p0     <= req_eat;
      req_tick_p0    <= req_tick;
      vsync_p0       <= vsync;
      failure        <= fail_e;
      success        <= pop & (fifo_head == SEV_SUCCESS);
      eat            <= pop & (fifo_head == SEV_EAT);
      tick           <= tick_ok;
      if (push_drop) overflow <= 1'b1;
      if (fail_e || pop)           hold <= HW'(HOLD_LONG);
      else if (tick_ok)            hold <= HW'(HOLD_TICK);
      else if (vs_e && !hold_zero) hold <= hold - HW'(1);
    end
  end

endmodule

// File: tb/tb_sound_event_queue.sv
// Directed bench for sound_event_queue (default parameters, optional coalesce build).
module tb_sound_event_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       req_failure;
  logic       req_success;
  logic       req_eat;
  logic       req_tick;
  logic       failure;
  logic       success;
  logic       eat;
  logic       tick;
  logic [2:0] queue_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int n_fail = 0, n_succ = 0, n_eat = 0, n_tick = 0, n_multi = 0;
  logic [3:0] ev;

`ifdef SOUND_EVQ_COALESCE_EN
  localparam int OVF_EATS = 1;
  localparam logic OVF_FLAG = 1'b0;
  localparam logic [2:0] OVF_COUNT = 3'd1;
`else
  localparam int OVF_EATS = 4;
  localparam logic OVF_FLAG = 1'b1;
  localparam logic [2:0] OVF_COUNT = 3'd4;
`endif

  always #5 clk = ~clk;

  sound_event_queue dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .req_failure (req_failure),
    .req_success (req_success),
    .req_eat     (req_eat),
    .req_tick    (req_tick),
    .failure     (failure),
    .success     (success),
    .eat         (eat),
    .tick        (tick),
    .queue_count (queue_count),
    .overflow    (overflow)
  );

  always @(posedge clk) begin
    #1;
    if (failure) n_fail++;
    if (success) n_succ++;
    if (eat)     n_eat++;
    if (tick)    n_tick++;
    if ((int'(failure) + int'(success) + int'(eat) + int'(tick)) > 1) n_multi++;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame();
    vsync = 1'b1;
    step();
    ev = {failure, success, eat, tick};
    vsync = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic drain();
    repeat (14) frame();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({failure, success, eat, tick} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses got %b want 0000", {failure, success, eat, tick});
    end
    checks++;
    if (queue_count !== 3'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", queue_count);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow got %b want 0", overflow);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_eat_held();
    int base;
    base = n_eat;
    req_eat = 1'b1;
    step();
    checks++;
    if (queue_count !== 3'd1) begin
      errors++; $display("FAIL held_count_push got %0d want 1", queue_count);
    end
    repeat (10) step();
    checks++;
    if (n_eat - base !== 0) begin
      errors++; $display("FAIL held_no_early got %0d want 0", n_eat - base);
    end
    frame();
    checks++;
    if (ev !== 4'b0010) begin
      errors++; $display("FAIL held_eat_pulse got %b want 0010", ev);
    end
    checks++;
    if (queue_count !== 3'd0) begin
      errors++; $display("FAIL held_count_pop got %0d want 0", queue_count);
    end
    checks++;
    if (dut.hold !== 4'd12) begin
      errors++; $display("FAIL held_hold got %0d want 12", dut.hold);
    end
    repeat (35) step();
    req_eat = 1'b0;
    step();
    drain();
    checks++;
    if (n_eat - base !== 1) begin
      errors++; $display("FAIL held_eat_total got %0d want 1", n_eat - base);
    end
  endtask

  task automatic test_eat_then_success();
    logic [3:0] exp;
    req_eat = 1'b1; step();
    req_eat = 1'b0; req_success = 1'b1; step();
    req_success = 1'b0; step();
    checks++;
    if (queue_count !== 3'd2) begin
      errors++; $display("FAIL es_count got %0d want 2", queue_count);
    end
    for (int i = 0; i < 14; i++) begin
      frame();
      exp = (i == 0) ? 4'b0010 : (i == 13) ? 4'b0100 : 4'b0000;
      checks++;
      if (ev !== exp) begin
        errors++; $display("FAIL es_frame%0d got %b want %b", i, ev, exp);
      end
    end
    checks++;
    if (queue_count !== 3'd0) begin
      errors++; $display("FAIL es_count_end got %0d want 0", queue_count);
    end
    drain();
  endtask

  task automatic test_failure_flush();
    int base;
    req_eat = 1'b1; step();
    req_eat = 1'b0; req_success = 1'b1; step();
    req_success = 1'b0; req_eat = 1'b1; step();
    req_eat = 1'b0; step();
    checks++;
    if (queue_count !== 3'd3) begin
      errors++; $display("FAIL ff_count_pre got %0d want 3", queue_count);
    end
    req_failure = 1'b1;
    step();
    checks++;
    if ({failure, success, eat, tick} !== 4'b1000) begin
      errors++; $display("FAIL ff_pulse got %b want 1000", {failure, success, eat, tick});
    end
    checks++;
    if (queue_count !== 3'd0) begin
      errors++; $display("FAIL ff_flush got %0d want 0", queue_count);
    end
    step();
    checks++;
    if (failure !== 1'b0) begin
      errors++; $display("FAIL ff_width got %b want 0", failure);
    end
    req_failure = 1'b0;
    base = n_succ + n_eat;
    drain();
    checks++;
    if (n_succ + n_eat - base !== 0) begin
      errors++; $display("FAIL ff_no_queued got %0d want 0", n_succ + n_eat - base);
    end
  endtask

  task automatic test_overflow();
    int base;
    logic [3:0] exp;
    req_failure = 1'b1; step();
    req_failure = 1'b0; step();
    for (int k = 0; k < 5; k++) begin
      req_eat = 1'b1; step();
      req_eat = 1'b0; step();
    end
    checks++;
    if (overflow !== OVF_FLAG) begin
      errors++; $display("FAIL ovf_flag got %b want %b", overflow, OVF_FLAG);
    end
    checks++;
    if (queue_count !== OVF_COUNT) begin
      errors++; $display("FAIL ovf_count got %0d want %0d", queue_count, OVF_COUNT);
    end
    base = n_eat;
    for (int i = 0; i < 53; i++) begin
      frame();
      exp = ((i % 13 == 12) && (i / 13 < OVF_EATS)) ? 4'b0010 : 4'b0000;
      checks++;
      if (ev !== exp) begin
        errors++; $display("FAIL ovf_frame%0d got %b want %b", i, ev, exp);
      end
    end
    checks++;
    if (n_eat - base !== OVF_EATS) begin
      errors++; $display("FAIL ovf_eat_total got %0d want %0d", n_eat - base, OVF_EATS);
    end
    drain();
    checks++;
    if (overflow !== OVF_FLAG) begin
      errors++; $display("FAIL ovf_sticky got %b want %b", overflow, OVF_FLAG);
    end
  endtask

  task automatic test_tick();
    int base;
    base = n_tick;
    req_tick = 1'b1; step();
    checks++;
    if ({failure, success, eat, tick} !== 4'b0001) begin
      errors++; $display("FAIL tick_first got %b want 0001", {failure, success, eat, tick});
    end
    req_tick = 1'b0; step();
    checks++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL tick_width got %b want 0", tick);
    end
    frame(); frame();
    req_tick = 1'b1; step();
    checks++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL tick_drop_f2 got %b want 0", tick);
    end
    req_tick = 1'b0; step();
    frame();
    req_tick = 1'b1; step();
    checks++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL tick_drop_f3 got %b want 0", tick);
    end
    req_tick = 1'b0; step();
    frame();
    vsync = 1'b1; req_tick = 1'b1; step();
    checks++;
    if ({failure, success, eat, tick} !== 4'b0001) begin
      errors++; $display("FAIL tick_f5 got %b want 0001", {failure, success, eat, tick});
    end
    vsync = 1'b0; req_tick = 1'b0; step();
    repeat (5) frame();
    req_eat = 1'b1; step();
    req_eat = 1'b0; req_tick = 1'b1; step();
    checks++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL tick_drop_queued got %b want 0", tick);
    end
    req_tick = 1'b0; step();
    frame();
    checks++;
    if (ev !== 4'b0010) begin
      errors++; $display("FAIL tick_queued_eat got %b want 0010", ev);
    end
    drain();
    req_tick = 1'b1; req_success = 1'b1; step();
    checks++;
    if ({failure, success, eat, tick} !== 4'b0000) begin
      errors++; $display("FAIL tick_with_succ got %b want 0000", {failure, success, eat, tick});
    end
    checks++;
    if (queue_count !== 3'd1) begin
      errors++; $display("FAIL tick_succ_count got %0d want 1", queue_count);
    end
    req_tick = 1'b0; req_success = 1'b0; step();
    frame();
    checks++;
    if (ev !== 4'b0100) begin
      errors++; $display("FAIL tick_succ_pop got %b want 0100", ev);
    end
    checks++;
    if (n_tick - base !== 2) begin
      errors++; $display("FAIL tick_total got %0d want 2", n_tick - base);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int base;
    req_failure = 1'b1; step();
    req_failure = 1'b0; step();
    req_success = 1'b1; step();
    req_success = 1'b0; req_eat = 1'b1; step();
    checks++;
    if (queue_count !== 3'd2) begin
      errors++; $display("FAIL rm_count_pre got %0d want 2", queue_count);
    end
    frame();
    rst = 1'b1;
    step();
    checks++;
    if ({failure, success, eat, tick, overflow} !== 5'b00000) begin
      errors++; $display("FAIL rm_outputs got %b want 00000", {failure, success, eat, tick, overflow});
    end
    checks++;
    if (queue_count !== 3'd0) begin
      errors++; $display("FAIL rm_count got %0d want 0", queue_count);
    end
    checks++;
    if (dut.hold !== 4'd0) begin
      errors++; $display("FAIL rm_hold got %0d want 0", dut.hold);
    end
    rst = 1'b0;
    step();
    base = n_fail + n_succ + n_eat + n_tick;
    repeat (15) frame();
    checks++;
    if (n_fail + n_succ + n_eat + n_tick - base !== 0) begin
      errors++; $display("FAIL rm_no_pulse got %0d want 0", n_fail + n_succ + n_eat + n_tick - base);
    end
    req_eat = 1'b0; step();
    req_eat = 1'b1; step();
    checks++;
    if (queue_count !== 3'd1) begin
      errors++; $display("FAIL rm_rearm_count got %0d want 1", queue_count);
    end
    frame();
    checks++;
    if (ev !== 4'b0010) begin
      errors++; $display("FAIL rm_rearm_eat got %b want 0010", ev);
    end
    req_eat = 1'b0;
    step();
  endtask

  task automatic test_onehot();
    checks++;
    if (n_multi !== 0) begin
      errors++; $display("FAIL onehot got %0d want 0", n_multi);
    end
  endtask

  initial begin
    rst = 1'b1;
    vsync = 1'b0;
    req_failure = 1'b0;
    req_success = 1'b0;
    req_eat = 1'b0;
    req_tick = 1'b0;
    @(negedge clk);
    test_reset();
    test_eat_held();
    test_eat_then_success();
    test_failure_flush();
    test_overflow();
    test_tick();
    test_reset_mid();
    test_onehot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
